// File: rtl/plic_gateway_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } gateway_state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/plic_gateway_if.sv
// Source/handshake bundle between a gateway and its surroundings.
interface plic_gateway_if #(
    parameter int COUNT_BITS = 4
);
    logic                  src_i;
    logic                  edge_lvl_i;
    logic                  claim_i;
    logic                  complete_i;
    logic                  ip_o;
    logic [COUNT_BITS-1:0] cnt_o;

    modport master (
        output src_i, edge_lvl_i, claim_i, complete_i,
        input  ip_o, cnt_o
    );

    modport slave (
        input  src_i, edge_lvl_i, claim_i, complete_i,
        output ip_o, cnt_o
    );
endinterface

// File: rtl/plic_gateway_counter.sv
// Saturating pending-edge counter: simultaneous inc/dec cancel, clear dominates.
module plic_gateway_counter #(
    parameter int  MAX_PENDING_COUNT = 8,
    localparam int COUNT_BITS        = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [COUNT_BITS-1:0] cnt_o
);
    localparam logic [COUNT_BITS-1:0] CNT_MAX = COUNT_BITS'(MAX_PENDING_COUNT);
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    logic [COUNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            // An edge arriving at the limit is dropped.
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: edge/level capture, one outstanding request,
// claim/complete handshake.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int  MAX_PENDING_COUNT = 8,
    localparam int COUNT_BITS        = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    plic_gateway_if.slave  gw
);
    gateway_state_t        state_q, state_d;
    logic                  ip_q, ip_d;
    logic                  src_q;
    logic                  edge_mode;
    logic                  src_edge;
    logic                  claim_acc;
    logic                  req;
    logic [COUNT_BITS-1:0] cnt;

    assign edge_mode = (gw.edge_lvl_i == MODE_EDGE);
    assign src_edge  = gw.src_i & ~src_q;
    assign claim_acc = (state_q == PENDING) & gw.claim_i;

    // Counter includes the request currently forwarded, so it drops on claim.
    plic_gateway_counter #(
        .MAX_PENDING_COUNT (MAX_PENDING_COUNT)
    ) u_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~edge_mode),
        .inc_i (edge_mode & src_edge),
        .dec_i (edge_mode & claim_acc),
        .cnt_o (cnt)
    );

    assign req = edge_mode ? ((cnt != '0) | src_edge) : gw.src_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req)           state_d = PENDING;
            PENDING: if (gw.claim_i)    state_d = CLAIMED;
            CLAIMED: if (gw.complete_i) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        ip_d = (state_d == PENDING);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ip_q    <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            src_q   <= gw.src_i;
        end
    end

    assign gw.ip_o  = ip_q;
    assign gw.cnt_o = cnt;
endmodule

// File: tb/tb_plic_gateway.sv
// Directed-vector bench for plic_gateway with a queued-expectation scoreboard.
module tb_plic_gateway;

    localparam int MAXC = 8;
    localparam int CB   = $clog2(MAXC + 1);

    typedef struct {
        logic  ip;
        int    cnt;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    plic_gateway_if #(.COUNT_BITS(CB)) bus ();

    plic_gateway #(.MAX_PENDING_COUNT(MAXC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .gw    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next posedge.
    task automatic step(input logic r, input logic m, input logic s,
                        input logic c, input logic p,
                        input logic e_ip, input int e_cnt, input string nm);
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.edge_lvl_i = m;
        bus.src_i      = s;
        bus.claim_i    = c;
        bus.complete_i = p;
        e.ip   = e_ip;
        e.cnt  = e_cnt;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, compare one expectation per clock.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (bus.ip_o !== e.ip || int'(bus.cnt_o) != e.cnt || $isunknown(bus.cnt_o)) begin
                n_bad++;
                $display("FAIL %s: got ip=%b cnt=%0d, want ip=%b cnt=%0d",
                         e.name, bus.ip_o, bus.cnt_o, e.ip, e.cnt);
            end
        end
    end

    initial begin
        int n;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.edge_lvl_i = 1'b0;
        bus.src_i      = 1'b0;
        bus.claim_i    = 1'b0;
        bus.complete_i = 1'b0;

        //    rst  mode src  clm  cmp   ip  cnt
        // Level mode basic handshake
        step(1, 0, 0, 0, 0,  0, 0, "reset");
        step(0, 0, 0, 0, 0,  0, 0, "lvl_idle");
        step(0, 0, 1, 0, 0,  1, 0, "lvl_req");
        step(0, 0, 1, 1, 0,  0, 0, "lvl_claim");
        step(0, 0, 0, 0, 1,  0, 0, "lvl_complete");
        step(0, 0, 0, 0, 0,  0, 0, "lvl_idle2");
        // Level held high; request never withdrawn; re-request after one IDLE cycle
        step(0, 0, 1, 0, 0,  1, 0, "lvl_req2");
        step(0, 0, 1, 0, 0,  1, 0, "lvl_hold");
        step(0, 0, 0, 0, 0,  1, 0, "lvl_no_withdraw");
        step(0, 0, 1, 1, 0,  0, 0, "lvl_claim2");
        step(0, 0, 1, 0, 0,  0, 0, "lvl_claimed_hold");
        step(0, 0, 1, 0, 1,  0, 0, "lvl_complete2");
        step(0, 0, 1, 0, 0,  1, 0, "lvl_rereq");
        step(0, 0, 1, 1, 0,  0, 0, "lvl_claim3");
        step(0, 0, 0, 0, 1,  0, 0, "lvl_complete3");
        // Claim in IDLE ignored; complete in PENDING ignored
        step(0, 0, 0, 1, 0,  0, 0, "claim_in_idle");
        step(0, 0, 1, 0, 0,  1, 0, "idle_kept");
        step(0, 0, 1, 0, 1,  1, 0, "complete_in_pending");
        step(0, 0, 1, 1, 0,  0, 0, "lvl_claim4");
        step(0, 0, 0, 0, 1,  0, 0, "lvl_complete4");

        // Edge mode: three edges before claim, then three handshakes
        step(0, 1, 0, 0, 0,  0, 0, "edg_idle");
        step(0, 1, 1, 0, 0,  1, 1, "edg_e1");
        step(0, 1, 0, 0, 0,  1, 1, "edg_low1");
        step(0, 1, 1, 0, 0,  1, 2, "edg_e2");
        step(0, 1, 0, 0, 0,  1, 2, "edg_low2");
        step(0, 1, 1, 0, 0,  1, 3, "edg_e3");
        step(0, 1, 0, 1, 0,  0, 2, "edg_claim_a");
        step(0, 1, 0, 0, 1,  0, 2, "edg_cmp_a");
        step(0, 1, 0, 0, 0,  1, 2, "edg_rereq_b");
        step(0, 1, 0, 1, 0,  0, 1, "edg_claim_b");
        step(0, 1, 0, 0, 1,  0, 1, "edg_cmp_b");
        step(0, 1, 0, 0, 0,  1, 1, "edg_rereq_c");
        step(0, 1, 0, 1, 0,  0, 0, "edg_claim_c");
        step(0, 1, 0, 0, 1,  0, 0, "edg_cmp_c");
        step(0, 1, 0, 0, 0,  0, 0, "edg_drained");
        step(0, 1, 0, 0, 0,  0, 0, "edg_drained2");

        // Edge coincident with accepted claim at cnt=2; claim/complete together
        step(0, 1, 1, 0, 0,  1, 1, "co_e1");
        step(0, 1, 0, 0, 0,  1, 1, "co_low1");
        step(0, 1, 1, 0, 0,  1, 2, "co_e2");
        step(0, 1, 0, 0, 0,  1, 2, "co_low2");
        step(0, 1, 1, 1, 0,  0, 2, "edge_with_claim");
        step(0, 1, 0, 1, 0,  0, 2, "claim_in_claimed");
        step(0, 1, 0, 0, 1,  0, 2, "co_cmp");
        step(0, 1, 0, 0, 0,  1, 2, "co_rereq");
        step(0, 1, 0, 1, 1,  0, 1, "claim_beats_complete");
        step(0, 1, 0, 0, 1,  0, 1, "co_cmp2");
        step(0, 1, 0, 0, 0,  1, 1, "co_rereq2");
        step(0, 1, 0, 1, 0,  0, 0, "co_claim3");

        // Saturation: 10 edges while CLAIMED
        for (int i = 1; i <= 10; i++) begin
            n = (i > MAXC) ? MAXC : i;
            step(0, 1, 1, 0, 0,  0, n, "sat_edge");
            step(0, 1, 0, 0, 0,  0, n, "sat_low");
        end
        step(0, 1, 0, 0, 1,  0, MAXC, "sat_cmp");
        for (int k = MAXC; k >= 1; k--) begin
            step(0, 1, 0, 0, 0,  1, k,     "sat_req");
            step(0, 1, 0, 1, 0,  0, k - 1, "sat_claim");
            step(0, 1, 0, 0, 1,  0, k - 1, "sat_cmp_k");
        end
        step(0, 1, 0, 0, 0,  0, 0, "sat_no_extra");
        step(0, 1, 0, 0, 0,  0, 0, "sat_no_extra2");

        // Reset while CLAIMED with cnt=5; src held high across reset
        step(0, 1, 1, 0, 0,  1, 1, "rs_e0");
        step(0, 1, 0, 1, 0,  0, 0, "rs_claim");
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 1, 0, 0,  0, i, "rs_edge");
            if (i != 5) step(0, 1, 0, 0, 0,  0, i, "rs_low");
        end
        step(1, 1, 1, 0, 0,  0, 0, "rst_in_claimed");
        step(0, 1, 1, 0, 0,  1, 1, "post_rst_edge");

        // Switch to level mode clears counter, state unchanged
        step(0, 1, 0, 0, 0,  1, 1, "mc_low");
        step(0, 1, 1, 0, 0,  1, 2, "mc_e");
        step(0, 0, 1, 0, 0,  1, 0, "mode_to_level");
        step(0, 0, 1, 1, 0,  0, 0, "mc_claim");
        step(0, 0, 0, 0, 1,  0, 0, "mc_cmp");
        step(0, 0, 0, 0, 0,  0, 0, "mc_idle");

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
